wb_pipelined_decoder: RTL and testbench
=======================================

Name: wb_pipelined_decoder

Overview:
- Parametrised Wishbone B4 pipelined 1-master-to-N-slave decoder/router for the data bus of core_wb.
- Decodes each request by base/mask per slave and forwards it to that slave.
- Tracks outstanding requests in an index FIFO so responses return to the master in order.
- Returns bus errors for unmapped addresses and for slaves that time out.

Parameters:
- NUM_SLAVES, 4, number of slave ports.
- ADR_W, 32, address width.
- DAT_W, 32, data width; SEL_W = DAT_W/8.
- MAX_OUTSTANDING, 4, tracking FIFO depth; power of two, at least 2.
- TIMEOUT_CYCLES, 255, cycles without a response before a forced error; 0 disables the timeout.
- SLAVE_BASE, {32'h3000,32'h2010,32'h2000,32'h0}, packed NUM_SLAVES*ADR_W base addresses, slave 0 in the LSBs.
- SLAVE_MASK, {32'hFFFF_F000,32'hFFFF_FFFC,32'hFFFF_FFF0,32'hFFFF_E000}, packed decode masks.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- m_cyc_i, m_stb_i, m_we_i  in  1 each  master cycle, strobe, write enable.
- m_adr_i  in  ADR_W  master address.
- m_dat_i  in  DAT_W  master write data.
- m_sel_i  in  SEL_W  master byte selects.
- m_stall_o, m_ack_o, m_err_o  out  1 each  to master.
- m_dat_o  out  DAT_W  read data to master.
- s_cyc_o, s_stb_o  out  NUM_SLAVES each  per-slave cycle and strobe.
- s_we_o  out  1  broadcast write enable.
- s_adr_o  out  ADR_W  broadcast address.
- s_dat_o  out  DAT_W  broadcast write data.
- s_sel_o  out  SEL_W  broadcast byte selects.
- s_stall_i, s_ack_i, s_err_i  in  NUM_SLAVES each  per-slave stall, ack, error.
- s_dat_i  in  NUM_SLAVES*DAT_W  packed read data.
- timeout_o  out  1  one-cycle pulse on timeout detection.

Behaviour:
- Decode (combinational):
  - hit[i] = ((m_adr_i & MASK[i]) == BASE[i]).
  - Target is the lowest-index hit.
  - No hit gives target MISS (= NUM_SLAVES).
- Stall:
  - m_stall_o = m_cyc_i & m_stb_i & (fifo_full | (fifo_nonempty & target != fifo_tail_idx) | flushing | (target != MISS & s_stall_i[target])).
  - The master may switch target only once the FIFO has drained; this is what guarantees in-order responses.
- Forwarding:
  - s_stb_o[i] = m_cyc_i & m_stb_i & target==i & ~(fifo_full | switch_block | flushing).
  - s_cyc_o[i] = m_cyc_i & ~flushing & ((fifo_nonempty & fifo_head_idx==i) | (m_stb_i & target==i)).
  - s_we_o, s_adr_o, s_dat_o and s_sel_o are broadcast unregistered.
- Accept:
  - A request is accepted when m_cyc_i & m_stb_i & ~m_stall_o.
  - On accept, push the target index, including MISS, into the FIFO.
- Response routing (combinational from the FIFO head h):
  - m_ack_o = s_ack_i[h].
  - m_err_o = s_err_i[h].
  - m_dat_o = s_dat_i[h].
  - Pop on ack or err.
  - Acks and errors from non-head slaves are ignored.
  - m_dat_o is 0 when the FIFO is empty or h == MISS.
- MISS:
  - When the head is MISS, m_err_o = 1 for exactly one cycle, then pop.
  - The error therefore appears the cycle after acceptance when the FIFO was otherwise empty.
- Simultaneous push and pop: permitted; count is unchanged.
  - When full, the master is stalled even if a pop occurs in the same cycle.
- Timeout counter:
  - Clears to 0 on reset, whenever the FIFO is empty, and on any pop.
  - Otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES with the FIFO non-empty: timeout_o pulses one cycle and the FLUSH state is entered.
- FSM:
  - IDLE -> ACTIVE when the FIFO becomes non-empty.
  - ACTIVE -> IDLE when the FIFO becomes empty.
  - ACTIVE -> FLUSH on timeout.
  - In FLUSH: m_err_o = 1 and one pop per cycle, until empty; then -> IDLE.
  - In FLUSH, slave acks are ignored and s_cyc_o is all 0.
- Master abort: m_cyc_i = 0 in any state empties the FIFO and clears the counter that cycle; the FSM goes to IDLE. No m_ack_o/m_err_o is issued while m_cyc_i = 0.
- Reset (async):
  - FIFO empty, counter 0, FSM IDLE.
  - All outputs 0, given m_cyc_i = 0.
  - Reset asserted mid-transaction discards all outstanding entries.

Decomposition:
- Shared package wb_pkg:
  - clog2 function.
  - MISS index localparam.
  - FSM state encoding IDLE/ACTIVE/FLUSH.
- One sub-module: wb_outstanding_fifo.
  - Synchronous FIFO with width clog2(NUM_SLAVES+1) and depth MAX_OUTSTANDING.
  - Outputs head, tail, full, empty and count.
  - Has a flush input.

Test Plan:
- Read from 0x0000_0100, slave 0 acks 1 cycle later with 0xDEADBEEF -> s_stb_o = 4'b0001; m_ack_o = 1 with m_dat_o = 0xDEADBEEF; FIFO empty afterwards.
- 4 back-to-back reads to 0x2000..0x200C, slave 1 holds ack -> 5th request stalls (m_stall_o = 1); 4 acks return in order; stall releases after the first pop.
- Read 0x2000 (slave 1) then 0x2010 (slave 2) pipelined -> 0x2010 stalls until slave 1 acks; then s_stb_o = 4'b0100.
- Access 0x0000_5000 (unmapped) -> no s_stb_o asserted; m_err_o = 1 exactly one cycle, the cycle after accept.
- Two requests to slave 3, slave never acks, TIMEOUT_CYCLES = 8 -> timeout_o pulses at cycle 8 after the last pop/push; m_err_o high 2 consecutive cycles; FSM returns to IDLE.
- 2 outstanding, then m_cyc_i dropped; and separately wb_rst_i asserted mid-burst -> FIFO empty immediately; late s_ack_i ignored (m_ack_o = 0); all outputs 0.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Purpose : Shared definitions for the Wishbone pipelined decoder:
//           ceiling-log2 helper, miss-index helper and FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package wb_pkg;

  // Slave count used when the decoder is built with default parameters.
  localparam int DEFAULT_NUM_SLAVES = 4;

  // Index one past the last slave marks an unmapped (MISS) request.
  localparam int DEFAULT_MISS_IDX = DEFAULT_NUM_SLAVES;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int miss_index(input int num_slaves);
    return num_slaves;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/wb_outstanding_fifo.sv
`default_nettype none
// ============================================================================
// Module  : wb_outstanding_fifo
// Purpose : Synchronous FIFO holding the slave index of every request still
//           awaiting a response. Exposes both ends so the decoder can route
//           responses (head) and block target switches (tail).
// Ports   : wb_clk_i/wb_rst_i  clock, async active-high reset
//           push/push_data      enqueue an index
//           pop                 dequeue the head (ignored when empty)
//           flush               empty the FIFO this cycle (wins over push/pop)
//           head/tail           oldest / newest stored index
//           full/empty/count    occupancy status
// Revision: 1.0 - initial release
// ============================================================================
module wb_outstanding_fifo
  import wb_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic [WIDTH-1:0]       tail,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] tail_idx;
  logic             do_push;
  logic             do_pop;

  assign count    = wr_ptr_q - rd_ptr_q;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign tail_idx = wr_ptr_q[PTR_W-1:0] - IDX_ONE;
  assign head     = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign tail     = mem_q[tail_idx];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_pipelined_decoder.sv
`default_nettype none
// ============================================================================
// Module  : wb_pipelined_decoder
// Purpose : Wishbone B4 pipelined 1-master to N-slave decoder. Requests are
//           decoded by base/mask, outstanding targets are queued so responses
//           return in order, and unmapped or timed-out requests get bus errors.
// Ports   : wb_clk_i/wb_rst_i       clock, async active-high reset
//           m_*                     master-side pipelined Wishbone
//           s_cyc_o/s_stb_o         per-slave cycle/strobe
//           s_we/adr/dat/sel_o      broadcast request fields
//           s_stall/ack/err/dat_i   per-slave responses (data packed)
//           timeout_o               one-cycle pulse when a slave times out
// Revision: 1.0 - initial release
// ============================================================================
module wb_pipelined_decoder
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES      = 4,
  parameter int ADR_W           = 32,
  parameter int DAT_W           = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_BASE =
    {32'h0000_3000, 32'h0000_2010, 32'h0000_2000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_MASK =
    {32'hFFFF_F000, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_E000}
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        m_cyc_i,
  input  logic                        m_stb_i,
  input  logic                        m_we_i,
  input  logic [ADR_W-1:0]            m_adr_i,
  input  logic [DAT_W-1:0]            m_dat_i,
  input  logic [DAT_W/8-1:0]          m_sel_i,
  output logic                        m_stall_o,
  output logic                        m_ack_o,
  output logic                        m_err_o,
  output logic [DAT_W-1:0]            m_dat_o,
  output logic [NUM_SLAVES-1:0]       s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  output logic                        s_we_o,
  output logic [ADR_W-1:0]            s_adr_o,
  output logic [DAT_W-1:0]            s_dat_o,
  output logic [DAT_W/8-1:0]          s_sel_o,
  input  logic [NUM_SLAVES-1:0]       s_stall_i,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES-1:0]       s_err_i,
  input  logic [NUM_SLAVES*DAT_W-1:0] s_dat_i,
  output logic                        timeout_o
);

  localparam int IDX_W = clog2(NUM_SLAVES + 1);
  localparam int FC_W  = clog2(MAX_OUTSTANDING) + 1;
  localparam int CNT_W = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] MISS      = IDX_W'(miss_index(NUM_SLAVES));
  localparam logic [FC_W-1:0]  FC_ONE    = FC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [IDX_W-1:0]   target;
  logic               tgt_stall;
  logic               req;
  logic               flushing;
  logic               switch_block;
  logic               accept;
  logic               pop;
  logic               will_empty;
  logic [IDX_W-1:0]   fifo_head;
  logic [IDX_W-1:0]   fifo_tail;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FC_W-1:0]    fifo_count;

  assign s_we_o  = m_we_i;
  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;

  // Lowest-index hit wins: scan from the top so lower slaves overwrite.
  always_comb begin
    target    = MISS;
    tgt_stall = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_adr_i & SLAVE_MASK[i*ADR_W +: ADR_W]) == SLAVE_BASE[i*ADR_W +: ADR_W]) begin
        target = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (target == IDX_W'(i)) begin
        tgt_stall = s_stall_i[i];
      end
    end
  end

  assign req          = m_cyc_i & m_stb_i;
  assign flushing     = (state_q == ST_FLUSH);
  // Switching slaves only after the queue drains keeps responses in order.
  assign switch_block = ~fifo_empty & (target != fifo_tail);
  assign m_stall_o    = req & (fifo_full | switch_block | flushing | tgt_stall);
  assign accept       = req & ~m_stall_o;

  always_comb begin
    s_stb_o = '0;
    s_cyc_o = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_stb_o[i] = req & (target == IDX_W'(i)) & ~(fifo_full | switch_block | flushing);
      s_cyc_o[i] = m_cyc_i & ~flushing &
                   ((~fifo_empty & (fifo_head == IDX_W'(i))) |
                    (m_stb_i & (target == IDX_W'(i))));
    end
  end

  // Responses come only from the slave at the queue head; everything else
  // is ignored. MISS and FLUSH entries produce an error and pop immediately.
  always_comb begin
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    m_dat_o = '0;
    pop     = 1'b0;
    if (m_cyc_i & ~fifo_empty) begin
      if (flushing || fifo_head == MISS) begin
        m_err_o = 1'b1;
      end else begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (fifo_head == IDX_W'(i)) begin
            m_ack_o = s_ack_i[i];
            m_err_o = s_err_i[i];
            m_dat_o = s_dat_i[i*DAT_W +: DAT_W];
          end
        end
      end
      pop = m_ack_o | m_err_o;
    end
  end

  // A response in the same cycle as the limit counts as an answer, not a timeout.
  assign timeout_o = (TIMEOUT_CYCLES != 0) & (state_q == ST_ACTIVE) & m_cyc_i &
                     ~fifo_empty & ~pop & (tmo_cnt_q >= TMO_LIMIT);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (~m_cyc_i | fifo_empty | pop) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != CNT_MAX) begin
      tmo_cnt_d = tmo_cnt_q + CNT_ONE;
    end
  end

  assign will_empty = ~m_cyc_i | (fifo_empty & ~accept) |
                      ((fifo_count == FC_ONE) & pop & ~accept);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (~m_cyc_i)       state_d = ST_IDLE;
        else if (timeout_o) state_d = ST_FLUSH;
        else if (will_empty) state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        if (will_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  wb_outstanding_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .push      (accept),
    .push_data (target),
    .pop       (pop),
    .flush     (~m_cyc_i),
    .head      (fifo_head),
    .tail      (fifo_tail),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_wb_pipelined_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_pipelined_decoder
// Purpose : Directed self-checking bench for wb_pipelined_decoder. Expected
//           master responses are queued as requests are issued and compared
//           in order whenever the decoder answers.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_pipelined_decoder;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic               wb_clk_i = 1'b0;
  logic               wb_rst_i;
  logic               m_cyc_i, m_stb_i, m_we_i;
  logic [AW-1:0]      m_adr_i;
  logic [DW-1:0]      m_dat_i;
  logic [DW/8-1:0]    m_sel_i;
  logic               m_stall_o, m_ack_o, m_err_o;
  logic [DW-1:0]      m_dat_o;
  logic [NS-1:0]      s_cyc_o, s_stb_o;
  logic               s_we_o;
  logic [AW-1:0]      s_adr_o;
  logic [DW-1:0]      s_dat_o;
  logic [DW/8-1:0]    s_sel_o;
  logic [NS-1:0]      s_stall_i, s_ack_i, s_err_i;
  logic [NS*DW-1:0]   s_dat_i;
  logic               timeout_o;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_pipelined_decoder #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_stall_o (m_stall_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_dat_o   (m_dat_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_stall_i (s_stall_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_dat_i   (s_dat_i),
    .timeout_o (timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge wb_clk_i);
  endtask

  task automatic expect_resp(input logic err, input logic [31:0] dat);
    resp_t r;
    r.err = err;
    r.dat = dat;
    exp_q.push_back(r);
  endtask

  // Scoreboard: every master response must match the oldest expectation.
  always @(negedge wb_clk_i) begin : mon
    resp_t e;
    if (m_ack_o || m_err_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        assert (1'b0) else begin
          n_fail++;
          $error("FAIL resp_unexpected: observed ack=%0b err=%0b expected no response",
                 m_ack_o, m_err_o);
        end
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        assert ({m_err_o, m_ack_o} === {e.err, ~e.err}) else begin
          n_fail++;
          $error("FAIL resp_kind: observed err=%0b ack=%0b expected err=%0b ack=%0b",
                 m_err_o, m_ack_o, e.err, ~e.err);
        end
        if (!e.err) begin
          n_checks++;
          assert (m_dat_o === e.dat) else begin
            n_fail++;
            $error("FAIL resp_data: observed %h expected %h", m_dat_o, e.dat);
          end
        end
      end
    end
  end

  initial begin
    wb_rst_i  = 1'b1;
    m_cyc_i   = 1'b0;
    m_stb_i   = 1'b0;
    m_we_i    = 1'b0;
    m_adr_i   = '0;
    m_dat_i   = '0;
    m_sel_i   = '0;
    s_stall_i = '0;
    s_ack_i   = '0;
    s_err_i   = '0;
    s_dat_i   = '0;

    // Reset state
    repeat (2) @(posedge wb_clk_i);
    sample();
    chk("rst_ctrl", {m_stall_o, m_ack_o, m_err_o, timeout_o, s_cyc_o, s_stb_o}, 64'h0);
    chk("rst_dat", m_dat_o, 64'h0);
    tick();
    wb_rst_i = 1'b0;

    // Single read to slave 0, ack one cycle later
    tick();
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h0000_0100;
    expect_resp(1'b0, 32'hDEAD_BEEF);
    sample();
    chk("t1_stb", s_stb_o, 64'b0001);
    chk("t1_stall", m_stall_o, 64'h0);
    chk("t1_adr", s_adr_o, 64'h100);
    tick();
    m_stb_i = 1'b0; s_ack_i = 4'b0001; s_dat_i[0*DW +: DW] = 32'hDEAD_BEEF;
    sample();
    chk("t1_ack", m_ack_o, 64'h1);
    tick();
    s_ack_i = '0;
    sample();
    chk("t1_empty", s_cyc_o, 64'h0);

    // Four back-to-back reads to slave 1 fill the queue
    for (int k = 0; k < 4; k++) begin
      tick();
      m_stb_i = 1'b1; m_adr_i = 32'h0000_2000 + 32'(4 * k);
      expect_resp(1'b0, 32'h1000 + 32'(k));
      sample();
      chk("t2_stb", s_stb_o, 64'b0010);
      chk("t2_stall", m_stall_o, 64'h0);
    end
    tick();
    m_adr_i = 32'h0000_2000;
    sample();
    chk("t2_full_stall", m_stall_o, 64'h1);
    chk("t2_full_stb", s_stb_o, 64'h0);
    tick();
    s_ack_i = 4'b0010; s_dat_i[1*DW +: DW] = 32'h1000;
    sample();
    chk("t2_full_pop_stall", m_stall_o, 64'h1);
    tick();
    s_dat_i[1*DW +: DW] = 32'h1001;
    expect_resp(1'b0, 32'h1004);
    sample();
    chk("t2_release_stall", m_stall_o, 64'h0);
    chk("t2_release_stb", s_stb_o, 64'b0010);
    for (int k = 2; k <= 4; k++) begin
      tick();
      m_stb_i = 1'b0; s_dat_i[1*DW +: DW] = 32'h1000 + 32'(k);
      sample();
    end
    tick();
    s_ack_i = '0;
    sample();
    chk("t2_empty", s_cyc_o, 64'h0);

    // Target switch waits for the queue to drain
    tick();
    m_stb_i = 1'b1; m_adr_i = 32'h0000_2000;
    expect_resp(1'b0, 32'h11);
    sample();
    chk("t3_stb_s1", s_stb_o, 64'b0010);
    tick();
    m_adr_i = 32'h0000_2010;
    sample();
    chk("t3_switch_stall", m_stall_o, 64'h1);
    chk("t3_switch_stb", s_stb_o, 64'h0);
    tick();
    s_ack_i = 4'b0010; s_dat_i[1*DW +: DW] = 32'h11;
    sample();
    chk("t3_pop_stall", m_stall_o, 64'h1);
    tick();
    s_ack_i = '0;
    expect_resp(1'b0, 32'h22);
    sample();
    chk("t3_go_stall", m_stall_o, 64'h0);
    chk("t3_stb_s2", s_stb_o, 64'b0100);
    tick();
    m_stb_i = 1'b0; s_ack_i = 4'b0100; s_dat_i[2*DW +: DW] = 32'h22;
    sample();
    tick();
    s_ack_i = '0;

    // Unmapped address
    tick();
    m_stb_i = 1'b1; m_adr_i = 32'h0000_5000;
    expect_resp(1'b1, 32'h0);
    sample();
    chk("t4_stb", s_stb_o, 64'h0);
    chk("t4_stall", m_stall_o, 64'h0);
    chk("t4_err_early", m_err_o, 64'h0);
    tick();
    m_stb_i = 1'b0;
    sample();
    chk("t4_err", m_err_o, 64'h1);
    chk("t4_dat", m_dat_o, 64'h0);
    tick();
    sample();
    chk("t4_err_once", m_err_o, 64'h0);

    // Slave 3 never answers: timeout then flush of both entries
    tick();
    m_stb_i = 1'b1; m_adr_i = 32'h0000_3000;
    expect_resp(1'b1, 32'h0);
    tick();
    m_adr_i = 32'h0000_3004;
    expect_resp(1'b1, 32'h0);
    tick();
    m_stb_i = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      sample();
      chk("t5_no_timeout", timeout_o, 64'h0);
      tick();
    end
    sample();
    chk("t5_timeout", timeout_o, 64'h1);
    chk("t5_no_err_yet", m_err_o, 64'h0);
    tick();
    sample();
    chk("t5_flush_err1", m_err_o, 64'h1);
    chk("t5_flush_cyc", s_cyc_o, 64'h0);
    chk("t5_pulse_once", timeout_o, 64'h0);
    tick();
    sample();
    chk("t5_flush_err2", m_err_o, 64'h1);
    tick();
    sample();
    chk("t5_idle_err", m_err_o, 64'h0);
    chk("t5_idle_cyc", s_cyc_o, 64'h0);

    // Master abort with two outstanding requests
    tick();
    m_stb_i = 1'b1; m_adr_i = 32'h0000_0010;
    tick();
    m_adr_i = 32'h0000_0014;
    tick();
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_adr_i = '0;
    s_ack_i = 4'b0001; s_dat_i[0*DW +: DW] = 32'h5555_AAAA;
    sample();
    chk("t6_abort_ack", m_ack_o, 64'h0);
    chk("t6_abort_cyc", s_cyc_o, 64'h0);
    tick();
    m_cyc_i = 1'b1;
    sample();
    chk("t6_late_ack", m_ack_o, 64'h0);
    chk("t6_late_cyc", s_cyc_o, 64'h0);
    tick();
    s_ack_i = '0;

    // Reset in the middle of a burst
    tick();
    m_stb_i = 1'b1; m_adr_i = 32'h0000_0020;
    tick();
    m_adr_i = 32'h0000_0024;
    tick();
    m_stb_i = 1'b0; m_adr_i = '0; wb_rst_i = 1'b1; s_ack_i = 4'b0001;
    sample();
    chk("t7_rst_ack", m_ack_o, 64'h0);
    chk("t7_rst_cyc", s_cyc_o, 64'h0);
    m_cyc_i = 1'b0;
    #1;
    chk("t7_rst_ctrl", {m_stall_o, m_ack_o, m_err_o, timeout_o, s_cyc_o, s_stb_o}, 64'h0);
    chk("t7_rst_dat", m_dat_o, 64'h0);
    tick();
    wb_rst_i = 1'b0; m_cyc_i = 1'b1;
    sample();
    chk("t7_late_ack", m_ack_o, 64'h0);
    tick();
    m_cyc_i = 1'b0; s_ack_i = '0;
    sample();

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
